hzu_scoreboard: RTL and testbench
=================================

// Module: hzu_scoreboard
// PURPOSE
//  Parametrised multithreaded RAW hazard unit sitting between fetch/decode and issue.
//  Keeps an in-flight window of the last DEPTH issued instructions (thread, dst).
//  Checks each incoming instruction's sources against older same-thread producers.
//  Also qualifies it with I-TLB/I-cache misses and supports per-thread window flush.
//  Emits a registered isvalid, a hazard flag and a saturating stall counter.
// PARAMETERS
//  N_THREADS  4   hardware threads; TID_W = $clog2(N_THREADS) (min 1)
//  REG_W      5   register index width
//  DEPTH      8   in-flight window length (ages 1..DEPTH), >= 1
//  BYP_AGE    3   min producer age resolved by forwarding (only with BYPASS_EN), 1..DEPTH
//  CNT_W      16  hazard counter width
// PORTS
//  clk          in   1      clock
//  rst          in   1      reset, synchronous, active-high
//  in_valid     in   1      decoded instruction present this cycle
//  in_thread    in   TID_W  issuing thread
//  in_src1      in   REG_W  source 1 index (always checked)
//  in_src2      in   REG_W  source 2 index
//  in_has_src2  in   1      src2 is a real operand
//  in_dst       in   REG_W  destination index
//  in_has_dst   in   1      instruction writes in_dst
//  itlb_miss    in   1      I-TLB miss for this instruction
//  icache_miss  in   1      I-cache miss for this instruction
//  flush_valid  in   1      kill all in-flight entries of flush_thread
//  flush_thread in   TID_W  thread to flush
//  isvalid      out  1      previous-cycle instruction committed to issue
//  hazard       out  1      previous-cycle instruction blocked by RAW hazard
//  hazard_cnt   out  CNT_W  saturating count of hazard-blocked cycles
// BEHAVIOUR
//  - Window: shift register hist[0..DEPTH-1] of {valid, thread, dst, has_dst}; hist[k] has age k+1.
//  - Shifts every cycle, including cycles with in_valid=0 (bubble enters as valid=0). hist[DEPTH-1] retires.
//  - Match at cycle t: hist[k].valid & hist[k].has_dst & hist[k].thread==in_thread &
//    (in_src1==hist[k].dst | (in_has_src2 & in_src2==hist[k].dst)); raw = OR over k.
//  - Check uses window contents before the shift at t (strictly older instrs only).
//  - Latency 1: at t+1 hist[0] = incoming; hist[0].valid = in_valid & ~itlb_miss & ~icache_miss & ~raw.
//  - Outputs at t+1: isvalid = hist[0].valid; hazard = in_valid & raw
//    (reported even when a miss also present).
//  - Blocked/missed instructions never enter window as producers; refetch is upstream's job.
//  - hazard_cnt increments at t+1 when hazard set; saturates at 2^CNT_W-1, never wraps.
//  - Flush at t: every entry with thread==flush_thread has valid cleared before the shift.
//  - Flush at t, same thread: match check ignores flushed entries.
//    Incoming in_valid of same thread is also dropped (isvalid=0, hazard=0).
//  - Flush of thread A never affects thread B entries or B's incoming instruction.
//  - Register 0 is not special; an instruction writing and reading the same reg does not self-hazard.
//  - Reset (any cycle, incl. mid-stream): all hist valid=0, isvalid=0, hazard=0, hazard_cnt=0; next-cycle checks see empty window.
// CONFIGURATION
//  - HZU_BYPASS_EN defined: matches with producer age >= BYP_AGE are ignored (forwarding covers them).
//    Only ages 1..BYP_AGE-1 can raise hazard.
//  - HZU_BYPASS_EN undefined: all DEPTH ages checked; BYP_AGE unused.
// TESTING
//  1 reset then T0 add dst=3; next cycle T0 src1=3 -> isvalid=0, hazard=1, hazard_cnt=1.
//  2 T0 dst=3, then T1 src1=3 -> isvalid=1, hazard=0 (thread isolation).
//  3 T0 dst=5, 8 bubbles, T0 src2=5 has_src2=1 (DEPTH=8) -> isvalid=1 (producer retired).
//    Same at 7 bubbles -> hazard=1.
//  4 T0 src2=5 with has_src2=0 after T0 dst=5 -> hazard=0, isvalid=1.
//    icache_miss=1 alone -> isvalid=0, hazard=0, instr not a producer.
//  5 T2 dst=7; flush_valid=1 flush_thread=2 same cycle as T2 src1=7 -> isvalid=0, hazard=0.
//    Next T2 src1=7 -> isvalid=1.
//  6 HZU_BYPASS_EN, BYP_AGE=3: T0 dst=4, 2 bubbles, T0 src1=4 -> isvalid=1.
//    1 bubble -> hazard=1. Without macro both -> hazard=1.
//    CNT_W=2: 4 hazards -> hazard_cnt stays 3.

Source files
------------

// File: rtl/hzu_scoreboard.sv
// Multithreaded RAW hazard unit: in-flight window of recent producers per thread,
// I-TLB/I-cache qualification, per-thread flush. Optional macro HZU_BYPASS_EN.
module hzu_scoreboard #(
    parameter int unsigned N_THREADS = 4,
    parameter int unsigned REG_W     = 5,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned BYP_AGE   = 3,
    parameter int unsigned CNT_W     = 16,
    localparam int unsigned TID_W    = (N_THREADS > 1) ? $clog2(N_THREADS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [TID_W-1:0] in_thread,
    input  logic [REG_W-1:0] in_src1,
    input  logic [REG_W-1:0] in_src2,
    input  logic             in_has_src2,
    input  logic [REG_W-1:0] in_dst,
    input  logic             in_has_dst,
    input  logic             itlb_miss,
    input  logic             icache_miss,
    input  logic             flush_valid,
    input  logic [TID_W-1:0] flush_thread,
    output logic             isvalid,
    output logic             hazard,
    output logic [CNT_W-1:0] hazard_cnt
);

`ifdef HZU_BYPASS_EN
    // Producers aged BYP_AGE or older are covered by forwarding.
    localparam int unsigned ChkAges = BYP_AGE - 1;
`else
    localparam int unsigned ChkAges = DEPTH;
`endif

    logic             hist_valid_q   [DEPTH];
    logic [TID_W-1:0] hist_thread_q  [DEPTH];
    logic [REG_W-1:0] hist_dst_q     [DEPTH];
    logic             hist_has_dst_q [DEPTH];

    logic             live_valid [DEPTH];
    logic             raw;
    logic             in_flushed;
    logic             in_live;
    logic             issue_d;
    logic             hazard_d;

    logic             isvalid_q;
    logic             hazard_q;
    logic [CNT_W-1:0] cnt_q;

    always_comb begin
        raw = 1'b0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            // Flushed entries are invisible to this cycle's check and to the shift.
            live_valid[k] = hist_valid_q[k] &
                            ~(flush_valid && (hist_thread_q[k] == flush_thread));
            if (k < int'(ChkAges) && live_valid[k] && hist_has_dst_q[k] &&
                (hist_thread_q[k] == in_thread) &&
                ((in_src1 == hist_dst_q[k]) ||
                 (in_has_src2 && (in_src2 == hist_dst_q[k])))) begin
                raw = 1'b1;
            end
        end
        in_flushed = flush_valid && (flush_thread == in_thread);
        in_live    = in_valid & ~in_flushed;
        issue_d    = in_live & ~itlb_miss & ~icache_miss & ~raw;
        hazard_d   = in_live & raw;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                hist_valid_q[k] <= 1'b0;
            end
            isvalid_q <= 1'b0;
            hazard_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            hist_valid_q[0] <= issue_d;
            for (int k = 1; k < int'(DEPTH); k++) begin
                hist_valid_q[k] <= live_valid[k-1];
            end
            isvalid_q <= issue_d;
            hazard_q  <= hazard_d;
            if (hazard_d && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Payload fields need no reset; valid gates every use.
    always_ff @(posedge clk) begin
        hist_thread_q[0]  <= in_thread;
        hist_dst_q[0]     <= in_dst;
        hist_has_dst_q[0] <= in_has_dst;
        for (int k = 1; k < int'(DEPTH); k++) begin
            hist_thread_q[k]  <= hist_thread_q[k-1];
            hist_dst_q[k]     <= hist_dst_q[k-1];
            hist_has_dst_q[k] <= hist_has_dst_q[k-1];
        end
    end

    assign isvalid    = isvalid_q;
    assign hazard     = hazard_q;
    assign hazard_cnt = cnt_q;

endmodule

// File: tb/tb_hzu_scoreboard.sv
// Directed self-checking bench for hzu_scoreboard; a second CNT_W=2 instance checks saturation.
module tb_hzu_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [1:0]  in_thread;
    logic [4:0]  in_src1;
    logic [4:0]  in_src2;
    logic        in_has_src2;
    logic [4:0]  in_dst;
    logic        in_has_dst;
    logic        itlb_miss;
    logic        icache_miss;
    logic        flush_valid;
    logic [1:0]  flush_thread;
    logic        isvalid;
    logic        hazard;
    logic [15:0] hazard_cnt;
    logic        sat_isvalid;
    logic        sat_hazard;
    logic [1:0]  sat_cnt;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hzu_scoreboard dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_thread(in_thread),
        .in_src1(in_src1), .in_src2(in_src2), .in_has_src2(in_has_src2),
        .in_dst(in_dst), .in_has_dst(in_has_dst), .itlb_miss(itlb_miss),
        .icache_miss(icache_miss), .flush_valid(flush_valid), .flush_thread(flush_thread),
        .isvalid(isvalid), .hazard(hazard), .hazard_cnt(hazard_cnt)
    );

    hzu_scoreboard #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_thread(in_thread),
        .in_src1(in_src1), .in_src2(in_src2), .in_has_src2(in_has_src2),
        .in_dst(in_dst), .in_has_dst(in_has_dst), .itlb_miss(itlb_miss),
        .icache_miss(icache_miss), .flush_valid(flush_valid), .flush_thread(flush_thread),
        .isvalid(sat_isvalid), .hazard(sat_hazard), .hazard_cnt(sat_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_thread = 0; in_src1 = 0; in_src2 = 0; in_has_src2 = 0;
        in_dst = 0; in_has_dst = 0; itlb_miss = 0; icache_miss = 0;
        flush_valid = 0; flush_thread = 0;
    endtask

    task automatic drive(input logic [1:0] th, input logic [4:0] s1, input logic [4:0] s2,
                         input logic hs2, input logic [4:0] d, input logic hd);
        idle();
        in_valid = 1; in_thread = th; in_src1 = s1; in_src2 = s2;
        in_has_src2 = hs2; in_dst = d; in_has_dst = hd;
    endtask

    task automatic bubbles(input int n);
        idle();
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        drive(2'd0, 5'd0, 5'd0, 0, 5'd3, 1);
        tick();
        tick();
        n_cmp++; if (isvalid !== 1'b0) begin n_fail++; $display("FAIL reset_isvalid: got %0b want 0", isvalid); end
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard: got %0b want 0", hazard); end
        n_cmp++; if (hazard_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", hazard_cnt); end
        // Mid-stream reset: producer issued, then reset, then consumer sees empty window.
        rst = 0;
        drive(2'd0, 5'd0, 5'd0, 0, 5'd3, 1);
        tick();
        do_reset();
        drive(2'd0, 5'd3, 5'd0, 0, 5'd3, 1);
        tick();
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL midreset_isvalid: got %0b want 1", isvalid); end
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL midreset_hazard: got %0b want 0", hazard); end
    endtask

    task automatic test_basic_raw();
        do_reset();
        drive(2'd0, 5'd0, 5'd0, 0, 5'd3, 1);
        tick();
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL raw_prod_isvalid: got %0b want 1", isvalid); end
        drive(2'd0, 5'd3, 5'd0, 0, 5'd9, 1);
        tick();
        n_cmp++; if (isvalid !== 1'b0) begin n_fail++; $display("FAIL raw_isvalid: got %0b want 0", isvalid); end
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL raw_hazard: got %0b want 1", hazard); end
        n_cmp++; if (hazard_cnt !== 16'd1) begin n_fail++; $display("FAIL raw_cnt: got %0d want 1", hazard_cnt); end
        // Register 0 is an ordinary register.
        drive(2'd1, 5'd1, 5'd0, 0, 5'd0, 1);
        tick();
        drive(2'd1, 5'd0, 5'd0, 0, 5'd2, 1);
        tick();
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL r0_hazard: got %0b want 1", hazard); end
        n_cmp++; if (hazard_cnt !== 16'd2) begin n_fail++; $display("FAIL r0_cnt: got %0d want 2", hazard_cnt); end
    endtask

    task automatic test_thread_isolation();
        do_reset();
        drive(2'd0, 5'd0, 5'd0, 0, 5'd3, 1);
        tick();
        drive(2'd1, 5'd3, 5'd0, 0, 5'd10, 1);
        tick();
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL iso_isvalid: got %0b want 1", isvalid); end
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL iso_hazard: got %0b want 0", hazard); end
    endtask

    task automatic test_window_retire();
        do_reset();
        drive(2'd0, 5'd1, 5'd0, 0, 5'd5, 1);
        tick();
        bubbles(8);
        drive(2'd0, 5'd2, 5'd5, 1, 5'd11, 1);
        tick();
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL retire9_isvalid: got %0b want 1", isvalid); end
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL retire9_hazard: got %0b want 0", hazard); end
        do_reset();
        drive(2'd0, 5'd1, 5'd0, 0, 5'd5, 1);
        tick();
        bubbles(7);
        drive(2'd0, 5'd2, 5'd5, 1, 5'd11, 1);
        tick();
`ifdef HZU_BYPASS_EN
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL age8_hazard: got %0b want 0", hazard); end
`else
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL age8_hazard: got %0b want 1", hazard); end
`endif
    endtask

    task automatic test_src2_and_miss();
        do_reset();
        drive(2'd0, 5'd1, 5'd0, 0, 5'd5, 1);
        tick();
        drive(2'd0, 5'd1, 5'd5, 0, 5'd12, 1);
        tick();
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL nosrc2_hazard: got %0b want 0", hazard); end
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL nosrc2_isvalid: got %0b want 1", isvalid); end
        do_reset();
        drive(2'd0, 5'd1, 5'd0, 0, 5'd6, 1);
        icache_miss = 1;
        tick();
        n_cmp++; if (isvalid !== 1'b0) begin n_fail++; $display("FAIL icmiss_isvalid: got %0b want 0", isvalid); end
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL icmiss_hazard: got %0b want 0", hazard); end
        drive(2'd0, 5'd6, 5'd0, 0, 5'd7, 1);
        tick();
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL icmiss_noprod: got %0b want 1", isvalid); end
        // Hazard is still reported when a miss coincides with it.
        drive(2'd0, 5'd7, 5'd0, 0, 5'd8, 1);
        itlb_miss = 1;
        tick();
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL itlb_hazard: got %0b want 1", hazard); end
        n_cmp++; if (isvalid !== 1'b0) begin n_fail++; $display("FAIL itlb_isvalid: got %0b want 0", isvalid); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(2'd2, 5'd0, 5'd0, 0, 5'd7, 1);
        tick();
        drive(2'd2, 5'd7, 5'd0, 0, 5'd13, 1);
        flush_valid = 1; flush_thread = 2'd2;
        tick();
        n_cmp++; if (isvalid !== 1'b0) begin n_fail++; $display("FAIL flush_isvalid: got %0b want 0", isvalid); end
        n_cmp++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL flush_hazard: got %0b want 0", hazard); end
        drive(2'd2, 5'd7, 5'd0, 0, 5'd13, 1);
        tick();
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL postflush_isvalid: got %0b want 1", isvalid); end
        // Flushing thread 2 leaves thread 1 producers and thread 0 incoming alone.
        do_reset();
        drive(2'd1, 5'd0, 5'd0, 0, 5'd8, 1);
        tick();
        drive(2'd1, 5'd8, 5'd0, 0, 5'd14, 1);
        flush_valid = 1; flush_thread = 2'd2;
        tick();
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL flushB_hazard: got %0b want 1", hazard); end
        drive(2'd0, 5'd1, 5'd0, 0, 5'd15, 1);
        flush_valid = 1; flush_thread = 2'd2;
        tick();
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL flushB_isvalid: got %0b want 1", isvalid); end
    endtask

    task automatic test_bypass();
        do_reset();
        drive(2'd0, 5'd0, 5'd0, 0, 5'd4, 1);
        tick();
        bubbles(2);
        drive(2'd0, 5'd4, 5'd0, 0, 5'd16, 1);
        tick();
`ifdef HZU_BYPASS_EN
        n_cmp++; if (isvalid !== 1'b1) begin n_fail++; $display("FAIL byp_age3_isvalid: got %0b want 1", isvalid); end
`else
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL byp_age3_hazard: got %0b want 1", hazard); end
`endif
        do_reset();
        drive(2'd0, 5'd0, 5'd0, 0, 5'd4, 1);
        tick();
        bubbles(1);
        drive(2'd0, 5'd4, 5'd0, 0, 5'd16, 1);
        tick();
        n_cmp++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL byp_age2_hazard: got %0b want 1", hazard); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(2'd0, 5'd0, 5'd0, 0, 5'd4, 1);
            tick();
            drive(2'd0, 5'd4, 5'd0, 0, 5'd20, 1);
            tick();
            if (i == 2) begin
                n_cmp++; if (sat_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_at3: got %0d want 3", sat_cnt); end
            end
        end
        idle();
        tick();
        n_cmp++; if (sat_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_hold: got %0d want 3", sat_cnt); end
        n_cmp++; if (hazard_cnt !== 16'd4) begin n_fail++; $display("FAIL wide_cnt4: got %0d want 4", hazard_cnt); end
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_basic_raw();
        test_thread_isolation();
        test_window_retire();
        test_src2_and_miss();
        test_flush();
        test_bypass();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
